// File: rtl/led_chase_sequencer.sv
// rtl/led_chase_sequencer.sv - 8-LED chaser sequencer: step prescaler, pattern FSM, registered LED bus
// Optional LED_PAUSE_BLINK_EN: paused output blinks the frozen pattern at the step rate.
`timescale 1ns/1ps
module led_chase_sequencer #(
   parameter int DIV    = 4,
   parameter int REPEAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SS,
   input  logic       MODE,
   input  logic [1:0] SEL,
   output logic [7:0] out,
   output logic [1:0] pattern,
   output logic       step_tick,
   output logic       cycle_done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(REPEAT + 1);
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
   localparam logic [CW-1:0] PREP  = CW'(REPEAT);

   typedef enum logic [1:0] {
      P_FILL    = 2'd0,
      P_DRAIN   = 2'd1,
      P_CHASE_L = 2'd2,
      P_CHASE_R = 2'd3
   } pat_t;

   pat_t          pat_q, pat_n;
   logic [3:0]    step, step_n, last;
   logic [PW-1:0] pcnt, pcnt_n;
   logic [CW-1:0] pass_cnt, pass_n, pass_inc;
   logic [7:0]    out_n;
   logic          tick, run, cd_n;

   function automatic logic [7:0] led_for(input pat_t p, input logic [3:0] k);
      logic [8:0] fill;
      fill = (9'd1 << k) - 9'd1;
      case (p)
         P_FILL:    led_for = fill[7:0];
         P_DRAIN:   led_for = 8'hFF >> k;
         P_CHASE_L: led_for = 8'h01 << k;
         default:   led_for = 8'h80 >> k;
      endcase
   endfunction

`ifdef LED_PAUSE_BLINK_EN
   logic blank, blank_n, paused_q;
   // The first SS=1 edge after a pause only restores the frozen output and re-arms the prescaler.
   assign run = SS && !paused_q;
`else
   assign run = SS;
`endif

   always_comb begin
      pcnt_n   = pcnt;
      step_n   = step;
      pat_n    = pat_q;
      pass_n   = pass_cnt;
      cd_n     = 1'b0;
      pass_inc = pass_cnt + CW'(1);
      last     = (pat_q == P_FILL || pat_q == P_DRAIN) ? 4'd8 : 4'd7;
      tick     = run && (pcnt == PLAST);

      if (run)
         pcnt_n = tick ? '0 : pcnt + PW'(1);

      if (tick) begin
         if (step == last) begin
            step_n = 4'd0;
            pass_n = pass_inc;
            // MODE and SEL only take effect here, so a pass always completes.
            if (MODE) begin
               if (pass_inc >= PREP) begin
                  pat_n  = pat_t'(pat_q + 2'd1);
                  pass_n = '0;
                  cd_n   = (pat_q == P_CHASE_R);
               end
            end else begin
               pat_n  = pat_t'(SEL);
               pass_n = '0;
            end
         end else begin
            step_n = step + 4'd1;
         end
      end

`ifdef LED_PAUSE_BLINK_EN
      blank_n = blank;
      if (!SS) begin
         pcnt_n = (pcnt == PLAST) ? '0 : pcnt + PW'(1);
         if (pcnt == PLAST)
            blank_n = ~blank;
      end else if (paused_q) begin
         pcnt_n  = '0;
         blank_n = 1'b0;
      end
      out_n = blank_n ? 8'h00 : led_for(pat_n, step_n);
`else
      out_n = led_for(pat_n, step_n);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q      <= P_FILL;
         step       <= 4'd0;
         pcnt       <= '0;
         pass_cnt   <= '0;
         out        <= 8'h00;
         step_tick  <= 1'b0;
         cycle_done <= 1'b0;
      end else begin
         pat_q      <= pat_n;
         step       <= step_n;
         pcnt       <= pcnt_n;
         pass_cnt   <= pass_n;
         out        <= out_n;
         step_tick  <= tick;
         cycle_done <= cd_n;
      end
   end

`ifdef LED_PAUSE_BLINK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank    <= 1'b0;
         paused_q <= 1'b0;
      end else begin
         blank    <= blank_n;
         paused_q <= !SS;
      end
   end
`endif

   assign pattern = pat_q;

endmodule

// File: doc/led_chase_sequencer.md
# led_chase_sequencer

Sequencing controller for the 8-LED "sang dan" light-chaser datapath. It divides the system clock into step ticks, runs a pattern state machine (fill, drain, chase-left, chase-right) and drives the 8-bit LED bus. It takes the same SS (run/stop) and MODE controls as the chaser top, and adds a manual pattern select plus status outputs for the display and board top.

## Interface
Parameters:
- DIV, 4: system clocks per step tick; legal range ≥1.
- REPEAT, 1: passes of each pattern before auto mode advances; legal range ≥1.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- SS  in  1  run level: 1 = run, 0 = pause (freeze).
- MODE  in  1  1 = auto-cycle patterns 0→1→2→3→0; 0 = manual, pattern taken from SEL.
- SEL  in  2  manual pattern select, used only when MODE=0.
- out  out  8  LED bus, registered.
- pattern  out  2  current pattern code, registered.
- step_tick  out  1  one-clk pulse on every step advance.
- cycle_done  out  1  one-clk pulse when auto mode wraps pattern 3→0.

## Operation
- Prescaler `pcnt`, width clog2(DIV), minimum 1 bit. While SS=1, it counts 0..DIV-1. On an edge with pcnt==DIV-1 and SS=1: pcnt←0, the step advances, and step_tick=1 for that cycle. With DIV=1, a tick occurs every SS=1 cycle.
- While SS=0: pcnt, step, pattern, pass count and out are all frozen, and step_tick=0. The partially counted prescaler value is retained.
- Patterns, as step index k → out:
  - P0 FILL: (1<<k)-1, k=0..8, giving 0x00,0x01,…,0xFF. Length L=9.
  - P1 DRAIN: 0xFF>>k, k=0..8, giving 0xFF,…,0x00. Length L=9.
  - P2 CHASE_L: 1<<k, k=0..7. Length L=8.
  - P3 CHASE_R: 0x80>>k, k=0..7. Length L=8.
- On a tick with step<L-1: step←step+1.
- On a tick with step==L-1 (pass boundary): step←0 and the pass count increments.
  - If MODE=1 and the pass count has reached REPEAT: pattern←pattern+1 mod 4 and the pass count clears. On the 3→0 wrap, cycle_done=1 on the same cycle as step_tick.
  - If MODE=0: pattern←SEL and the pass count clears.
- MODE and SEL are sampled only at pass boundaries. Changing them mid-pass never truncates the pass.
- out is registered as f(next pattern, next step) and updates on the same edge as step, so out always equals f(pattern, step).
- Reset mid-operation: all state returns to reset values asynchronously, with no clock edge required.

## Timing
- Reset values: out=0x00, pattern=0, step=0, pcnt=0, pass count=0, step_tick=0, cycle_done=0. This is consistent with P0 step 0.
- After reset release with SS=1, the first tick lands on the DIV-th rising edge and then every DIV edges. Latency from tick to out change is 0 cycles (same edge).
- Resume after pause at pcnt=p: the tick lands on the (DIV-p)-th SS=1 edge.
- In auto mode with REPEAT=1, a full cycle is 34 ticks (9+9+8+8).
- Simultaneous pass boundary and SS falling: SS is sampled on the edge, so if SS=0 on that edge, no advance occurs.
- Simultaneous reset and tick: reset wins.

## Configuration
- LED_PAUSE_BLINK_EN defined:
  - While SS=0, the prescaler keeps running but step and pattern stay frozen and step_tick stays 0.
  - Each prescaler wrap toggles out between the frozen value f(pattern, step) and 0x00, starting with 0x00 at the first wrap.
  - On SS returning to 1, out restores the frozen value on the next edge and pcnt restarts at 0.
- LED_PAUSE_BLINK_EN undefined: while paused, out holds static and the prescaler freezes, as described in Operation.

## Test plan
- DIV=4, reset, then SS=1, MODE=1 → out 0x00, then 0x01,0x03,…,0xFF at ticks 1–8, one tick per 4 clks. Tick 9: pattern=1, out=0xFF.
- Auto run for 34 ticks → pattern sequence 0,1,2,3. At tick 34: cycle_done high for exactly 1 clk coincident with step_tick, pattern=0, out=0x00.
- MODE=0, SEL=2 applied at P0 step 3 → P0 continues to 0xFF. Next tick: pattern=2, out=0x01, then 0x02,…,0x80, then 0x01 again (repeats P2).
- SS=0 at pcnt=2 during P3 with out=0x20, held for 10 clks → out holds 0x20, step_tick stays 0. After SS=1, the tick arrives on the 2nd edge and out=0x10.
- Assert reset mid-P2 between clock edges → out=0x00, pattern=0, and step_tick/cycle_done low, immediately with no clock edge.
- LED_PAUSE_BLINK_EN with DIV=4, paused at out=0x07 → out reads 0x00, 0x07, 0x00, … toggling every 4 clks. SS=1 → out=0x07 on the next edge, then the tick arrives 4 edges later with out=0x0F.
